register_file: RTL and testbench

//  Multi-entry general-purpose register file for the n-bit CPU. Generalises the single

---
 rtl/register_file.sv | 87 ++++++++
 tb/tb_register_file.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/register_file.sv
// Register file: one write port, two combinational read ports,
// optional write bypass and zero register, plus a per-register busy scoreboard.
module register_file #(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 8,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1,
  localparam int AW      = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [AW-1:0]    rd_addr_a,
  output logic [WIDTH-1:0] rd_data_a,
  input  logic [AW-1:0]    rd_addr_b,
  output logic [WIDTH-1:0] rd_data_b,
  input  logic             rsv_en,
  input  logic [AW-1:0]    rsv_addr,
  output logic             busy_a,
  output logic             busy_b,
  output logic             any_busy
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [DEPTH-1:0] busy;
  logic [DEPTH-1:0] wr_hit;
  logic [DEPTH-1:0] rsv_hit;

  // Out-of-range indices match no entry, so they fall out naturally
  always_comb begin
    wr_hit  = '0;
    rsv_hit = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (!(ZERO_REG != 0 && i == 0)) begin
        wr_hit[i]  = wr_en && (wr_addr == AW'(i));
        rsv_hit[i] = rsv_en && (rsv_addr == AW'(i));
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      busy <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (wr_hit[i]) begin
          mem[i] <= wr_data;
        end
        if (rsv_hit[i]) begin
          busy[i] <= 1'b1;
        end else if (wr_hit[i]) begin
          busy[i] <= 1'b0;
        end
      end
    end
  end

  always_comb begin
    rd_data_a = '0;
    rd_data_b = '0;
    busy_a    = 1'b0;
    busy_b    = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (rd_addr_a == AW'(i)) begin
        rd_data_a = (BYPASS != 0 && wr_hit[i]) ? wr_data : mem[i];
        busy_a    = busy[i];
      end
      if (rd_addr_b == AW'(i)) begin
        rd_data_b = (BYPASS != 0 && wr_hit[i]) ? wr_data : mem[i];
        busy_b    = busy[i];
      end
    end
    // Keep the bypass path from leaking wr_data while reset is held
    if (rst) begin
      rd_data_a = '0;
      rd_data_b = '0;
    end
  end

  assign any_busy = |busy;

endmodule

// File: tb/tb_register_file.sv
// Bench: three register_file variants share one stimulus stream
// and are compared against an array-based model of the register file.
module tb_register_file;

  logic       clk;
  logic       rst;
  logic       wr_en;
  logic [2:0] wr_addr;
  logic [7:0] wr_data;
  logic [2:0] rd_addr_a;
  logic [2:0] rd_addr_b;
  logic       rsv_en;
  logic [2:0] rsv_addr;

  logic [7:0] rda [3];
  logic [7:0] rdb [3];
  logic       ba  [3];
  logic       bb  [3];
  logic       ab  [3];

  int n_vec;
  int n_err;

  // bank 0 backs the two DEPTH=8 instances, bank 1 the DEPTH=6 one
  logic [7:0] mem [2][8];
  bit         bsy [2][8];

  register_file #(.WIDTH(8), .DEPTH(8), .ZERO_REG(1), .BYPASS(1)) u_dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .rd_addr_a(rd_addr_a), .rd_data_a(rda[0]),
    .rd_addr_b(rd_addr_b), .rd_data_b(rdb[0]), .rsv_en(rsv_en),
    .rsv_addr(rsv_addr), .busy_a(ba[0]), .busy_b(bb[0]),
    .any_busy(ab[0])
  );

  register_file #(.WIDTH(8), .DEPTH(8), .ZERO_REG(1), .BYPASS(0)) u_nb (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .rd_addr_a(rd_addr_a), .rd_data_a(rda[1]),
    .rd_addr_b(rd_addr_b), .rd_data_b(rdb[1]), .rsv_en(rsv_en),
    .rsv_addr(rsv_addr), .busy_a(ba[1]), .busy_b(bb[1]),
    .any_busy(ab[1])
  );

  register_file #(.WIDTH(8), .DEPTH(6), .ZERO_REG(1), .BYPASS(1)) u_d6 (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .rd_addr_a(rd_addr_a), .rd_data_a(rda[2]),
    .rd_addr_b(rd_addr_b), .rd_data_b(rdb[2]), .rsv_en(rsv_en),
    .rsv_addr(rsv_addr), .busy_a(ba[2]), .busy_b(bb[2]),
    .any_busy(ab[2])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int depth_of(int inst);
    return (inst == 2) ? 6 : 8;
  endfunction

  function automatic int bank_of(int inst);
    return (inst == 2) ? 1 : 0;
  endfunction

  function automatic logic [7:0] exp_rd(int inst, int a);
    int d = depth_of(inst);
    bit byp = (inst != 1);
    if (rst) return 8'h00;
    if (a >= d || a == 0) return 8'h00;
    if (byp && wr_en && int'(wr_addr) == a) return wr_data;
    return mem[bank_of(inst)][a];
  endfunction

  function automatic bit exp_busy(int inst, int a);
    if (a >= depth_of(inst)) return 1'b0;
    return bsy[bank_of(inst)][a];
  endfunction

  function automatic bit exp_any(int inst);
    bit r = 1'b0;
    for (int i = 0; i < depth_of(inst); i++) r |= bsy[bank_of(inst)][i];
    return r;
  endfunction

  task automatic model_clear();
    for (int m = 0; m < 2; m++) begin
      for (int i = 0; i < 8; i++) begin
        mem[m][i] = 8'h00;
        bsy[m][i] = 1'b0;
      end
    end
  endtask

  task automatic model_edge();
    int wa = int'(wr_addr);
    int ra = int'(rsv_addr);
    if (rst) begin
      model_clear();
      return;
    end
    for (int m = 0; m < 2; m++) begin
      int d = (m == 1) ? 6 : 8;
      bit wv = wr_en && wa < d && wa != 0;
      bit rv = rsv_en && ra < d && ra != 0;
      if (wv) mem[m][wa] = wr_data;
      if (wv) bsy[m][wa] = 1'b0;
      if (rv) bsy[m][ra] = 1'b1;
    end
  endtask

  task automatic check_all();
    for (int j = 0; j < 3; j++) begin
      check($sformatf("rd_a[%0d]", j), 32'(rda[j]),
            32'(exp_rd(j, int'(rd_addr_a))));
      check($sformatf("rd_b[%0d]", j), 32'(rdb[j]),
            32'(exp_rd(j, int'(rd_addr_b))));
      check($sformatf("busy_a[%0d]", j), 32'(ba[j]),
            32'(exp_busy(j, int'(rd_addr_a))));
      check($sformatf("busy_b[%0d]", j), 32'(bb[j]),
            32'(exp_busy(j, int'(rd_addr_b))));
      check($sformatf("any_busy[%0d]", j), 32'(ab[j]),
            32'(exp_any(j)));
    end
  endtask

  task automatic drive(bit we, int wa, int wd, int a, int b,
                       bit re, int r);
    wr_en     = we;
    wr_addr   = 3'(wa);
    wr_data   = 8'(wd);
    rd_addr_a = 3'(a);
    rd_addr_b = 3'(b);
    rsv_en    = re;
    rsv_addr  = 3'(r);
  endtask

  task automatic step();
    @(negedge clk);
    check_all();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    model_clear();
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0);
    step();
    rst = 1'b0;

    // reset while r3 is loaded and r2 is reserved
    drive(1, 3, 'h5A, 3, 2, 1, 2);
    step();
    drive(0, 0, 0, 3, 2, 0, 0);
    #2;
    check("r3_loaded", 32'(rda[0]), 32'h5A);
    check("r2_busy", 32'(bb[0]), 32'h1);
    rst = 1'b1;
    #1;
    model_clear();
    check("rst_rd3", 32'(rda[0]), 32'h00);
    check("rst_any", 32'(ab[0]), 32'h0);
    step();
    rst = 1'b0;

    // write / read / hold
    drive(1, 1, 'hA5, 0, 0, 0, 0);
    step();
    drive(1, 2, 'h3C, 0, 0, 0, 0);
    step();
    drive(0, 0, 0, 1, 2, 0, 0);
    step();
    step();
    check("hold_r1", 32'(rda[0]), 32'hA5);
    check("hold_r2", 32'(rdb[0]), 32'h3C);
    step();

    // bypass vs no bypass
    drive(1, 4, 'h11, 0, 0, 0, 0);
    step();
    drive(1, 4, 'h77, 4, 0, 0, 0);
    #2;
    check("byp_on", 32'(rda[0]), 32'h77);
    check("byp_off", 32'(rda[1]), 32'h11);
    step();

    // zero register
    drive(1, 0, 'hFF, 0, 0, 1, 0);
    step();
    drive(0, 0, 0, 0, 0, 0, 0);
    #2;
    check("zero_rd", 32'(rda[0]), 32'h00);
    check("zero_busy", 32'(ba[0]), 32'h0);
    check("zero_any", 32'(ab[0]), 32'h0);
    step();

    // scoreboard
    drive(0, 0, 0, 5, 0, 1, 5);
    step();
    drive(0, 0, 0, 5, 0, 0, 0);
    #2;
    check("r5_busy", 32'(ba[0]), 32'h1);
    check("r5_any", 32'(ab[0]), 32'h1);
    step();
    drive(1, 5, 'h42, 5, 0, 0, 0);
    step();
    drive(0, 0, 0, 5, 0, 0, 0);
    #2;
    check("r5_clear", 32'(ba[0]), 32'h0);
    check("r5_data", 32'(rda[0]), 32'h42);
    step();
    drive(1, 6, 'h66, 6, 0, 1, 6);
    step();
    drive(0, 0, 0, 6, 0, 0, 0);
    #2;
    check("r6_busy", 32'(ba[0]), 32'h1);
    check("r6_data", 32'(rda[0]), 32'h66);
    step();

    // out-of-range address on the DEPTH=6 instance
    drive(1, 7, 'h99, 7, 7, 1, 7);
    step();
    drive(0, 0, 0, 7, 6, 0, 0);
    #2;
    check("d6_rd7", 32'(rda[2]), 32'h00);
    check("d6_busy7", 32'(ba[2]), 32'h0);
    step();

    for (int n = 0; n < 1000; n++) begin
      drive(bit'($urandom_range(0, 1)), int'($urandom_range(0, 7)),
            int'($urandom_range(0, 255)), int'($urandom_range(0, 7)),
            int'($urandom_range(0, 7)), $urandom_range(0, 3) == 0,
            int'($urandom_range(0, 7)));
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
